// File: rtl/intr_ctrl_pkg.sv
// Shared constants, state encoding and address decode helper for intr_ctrl.
package intr_ctrl_pkg;

    // Byte addresses of the register map; bits [1:0] are never decoded.
    localparam logic [3:0] ADDR_PENDING = 4'h0;
    localparam logic [3:0] ADDR_ENABLE  = 4'h4;
    localparam logic [3:0] ADDR_CLAIM   = 4'h8;

    // Interrupt ID meaning "no source"; source i reports ID i+1.
    localparam logic [4:0] ID_NONE = 5'd0;

    // Controller state: IDLE (intr low), ASSERT (intr high), SERVICE (claimed).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } st_e;

    // Word-address match: compares only the word index bits.
    function automatic logic addr_hit(input logic [3:0] addr, input logic [3:0] base);
        return (addr[3:2] == base[3:2]);
    endfunction

endpackage

// File: rtl/intr_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
module intr_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two back-to-back capture stages to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/intr_ctrl.sv
// Platform interrupt controller: pending latch, fixed-priority arbitration,
// claim/complete handshake and an edge-friendly intr output.
module intr_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq,
    input  logic            reg_wr_en,
    input  logic            reg_rd_en,
    input  logic [3:0]      reg_addr,
    input  logic [31:0]     reg_wdat,
    output logic [31:0]     reg_rdat,
    output logic            reg_rd_valid,
    output logic            intr
);
    import intr_ctrl_pkg::*;

    logic [NSRC-1:0] sync_s;
    logic [NSRC-1:0] active_s;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [4:0]      svc_id_q, svc_id_d;
    logic [4:0]      best_id_s;
    st_e             st_q, st_d;
    logic            intr_q, intr_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            rd_valid_q, rd_valid_d;
    logic            claim_rd_s;
    logic            claim_ok_s;
    logic            complete_ok_s;
    logic            unused_s;

    // Address bits [1:0] and write-data bits beyond the used fields are don't-care.
    assign unused_s = ^{reg_addr[1:0], reg_wdat};

    intr_sync #(.W(NSRC)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (src_irq),
        .q   (sync_s)
    );

    assign active_s = pending_q & enable_q;

    // Fixed-priority encoder: the lowest active index wins, reported as index+1.
    always_comb begin
        best_id_s = ID_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active_s[i]) begin
                best_id_s = 5'(i + 1);
            end else begin
                best_id_s = best_id_s;
            end
        end
    end

    assign claim_rd_s    = reg_rd_en && addr_hit(reg_addr, ADDR_CLAIM);
    assign claim_ok_s    = claim_rd_s && (st_q != SERVICE) && (best_id_s != ID_NONE);
    assign complete_ok_s = reg_wr_en && addr_hit(reg_addr, ADDR_CLAIM) &&
                           (st_q == SERVICE) && (reg_wdat[4:0] == svc_id_q);

    // Pending bits: a claim clears its bit (and wins over a same-cycle set);
    // a synchronized level sets a bit unless that source is currently in service.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (claim_ok_s && (best_id_s == 5'(i + 1))) begin
                pending_d[i] = 1'b0;
            end else if (sync_s[i] && !((st_q == SERVICE) && (svc_id_q == 5'(i + 1)))) begin
                pending_d[i] = 1'b1;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Enable register write.
    always_comb begin
        if (reg_wr_en && addr_hit(reg_addr, ADDR_ENABLE)) begin
            enable_d = reg_wdat[NSRC-1:0];
        end else begin
            enable_d = enable_q;
        end
    end

    // Next-state logic: IDLE must be passed through before every new assertion
    // so the trap unit always sees a fresh rising edge.
    always_comb begin
        st_d     = st_q;
        svc_id_d = svc_id_q;
        case (st_q)
            IDLE: begin
                if (claim_ok_s) begin
                    st_d     = SERVICE;
                    svc_id_d = best_id_s;
                end else if ((best_id_s != ID_NONE) && !claim_rd_s) begin
                    st_d = ASSERT;
                end else begin
                    st_d = IDLE;
                end
            end
            ASSERT: begin
                if (claim_ok_s) begin
                    st_d     = SERVICE;
                    svc_id_d = best_id_s;
                end else if (best_id_s == ID_NONE) begin
                    st_d = IDLE;
                end else begin
                    st_d = ASSERT;
                end
            end
            SERVICE: begin
                if (complete_ok_s) begin
                    st_d     = IDLE;
                    svc_id_d = ID_NONE;
                end else begin
                    st_d = SERVICE;
                end
            end
            default: begin
                st_d     = IDLE;
                svc_id_d = ID_NONE;
            end
        endcase
    end

    assign intr_d = (st_q == ASSERT);

    // Read data mux; a claim read returns the winning ID only when it succeeds.
    always_comb begin
        rd_valid_d = reg_rd_en;
        rdat_d     = 32'd0;
        if (reg_rd_en) begin
            if (addr_hit(reg_addr, ADDR_PENDING)) begin
                rdat_d = 32'(pending_q);
            end else if (addr_hit(reg_addr, ADDR_ENABLE)) begin
                rdat_d = 32'(enable_q);
            end else if (addr_hit(reg_addr, ADDR_CLAIM)) begin
                rdat_d = claim_ok_s ? 32'(best_id_s) : 32'd0;
            end else begin
                rdat_d = 32'd0;
            end
        end else begin
            rdat_d = 32'd0;
        end
    end

    // State registers; reset abandons any claim or service immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            enable_q   <= '0;
            svc_id_q   <= ID_NONE;
            st_q       <= IDLE;
            intr_q     <= 1'b0;
            rdat_q     <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            svc_id_q   <= svc_id_d;
            st_q       <= st_d;
            intr_q     <= intr_d;
            rdat_q     <= rdat_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign intr         = intr_q;
    assign reg_rdat     = rdat_q;
    assign reg_rd_valid = rd_valid_q;

endmodule
